// File: rtl/id_scanner_pkg.sv
// Shared types and the ID digit table for the digit scanner.
// Mode/state encodings plus the fixed ID digit list.
package id_scanner_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'b00,
    MODE_RUN     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_STEP    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT,
    DONE
  } state_e;

  localparam int N_IDS = 8;

  localparam logic [3:0] ID_DIGITS [N_IDS] = '{
    4'd0, 4'd0, 4'd9, 4'd5,
    4'd7, 4'd2, 4'd0, 4'd2
  };

endpackage

// File: rtl/id_rom.sv
// Combinational ID digit lookup, zero beyond the list.
// Ports: addr (table index) -> data (digit, DATA_W bits).
module id_rom
  import id_scanner_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    for (int i = 0; i < N_IDS; i++) begin
      if (i < DEPTH && addr == ADDR_W'(i)) begin
        data = DATA_W'(ID_DIGITS[i]);
      end
    end
  end

endmodule

// File: rtl/id_digit_scanner.sv
// ID digit scanner: steps the ID table out over valid/ready.
// Ports: clk, rst, en, mode, dir, step, out_ready ->
//        out_valid, out_data, out_addr, done.
module id_digit_scanner
  import id_scanner_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int DIV    = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic              step,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic              moved_q;
  mode_e             md;
  logic              active;
  logic              step_mode;
  logic              at_end;
  logic              cnt_zero;
  logic              wait_stop;
  logic              wait_adv;
  logic              adv;
  logic              hs;

  assign md        = mode_e'(mode);
  assign active    = en && (md != MODE_HOLD);
  assign step_mode = (md == MODE_STEP);
  assign cnt_zero  = (cnt_q == '0);
  assign at_end    = dir ? (addr_q == '0)
                         : (addr_q == LAST);
  assign hs        = (state_q == PRESENT) && out_ready;

  // A oneshot scan that starts on the end address
  // makes a full lap before stopping there.
  assign wait_stop = !step_mode && cnt_zero &&
                     (md == MODE_ONESHOT) &&
                     at_end && moved_q;
  assign wait_adv  = step_mode ? step
                               : (cnt_zero && !wait_stop);

  always_comb begin
    if (dir) begin
      addr_nxt = (addr_q == '0) ? LAST
                 : addr_q - ADDR_W'(1);
    end else begin
      addr_nxt = (addr_q == LAST) ? '0
                 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    if (!active) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = PRESENT;
        PRESENT: begin
          if (out_ready) state_d = WAIT;
        end
        WAIT: begin
          unique case (1'b1)
            wait_stop: state_d = DONE;
            wait_adv: begin
              adv     = 1'b1;
              state_d = PRESENT;
            end
            default: ;
          endcase
        end
        DONE: begin
          if (md != MODE_ONESHOT) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      moved_q <= 1'b0;
    end else begin
      if (adv) addr_q <= addr_nxt;
      if (hs) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == WAIT &&
                   !step_mode && !cnt_zero) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (adv) begin
        moved_q <= 1'b1;
      end else if (state_q == IDLE) begin
        moved_q <= 1'b0;
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      PRESENT: out_valid = 1'b1;
      DONE:    done      = 1'b1;
      default: ;
    endcase
  end

  assign out_addr = addr_q;

  id_rom #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_rom (
    .addr(addr_q),
    .data(out_data)
  );

endmodule

// File: tb/tb_id_digit_scanner.sv
// Self-checking bench for id_digit_scanner.
// Directed scenarios plus random stimulus vs. a reference model.
module tb_id_digit_scanner;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;
  localparam int DIV    = 4;
  localparam int ADDR_W = 3;

  localparam int P_IDLE = 0;
  localparam int P_PRES = 1;
  localparam int P_WAIT = 2;
  localparam int P_DONE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              dir = 1'b0;
  logic              step = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              done;

  always #5 clk = ~clk;

  id_digit_scanner #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .DIV   (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .step     (step),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_addr (out_addr),
    .done     (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Reference model: position on the ID list, a phase,
  // the wait cycles left, and whether this run has moved.
  int digits [8] = '{0, 0, 9, 5, 7, 2, 0, 2};
  int m_ph   = P_IDLE;
  int m_pos  = 0;
  int m_left = 0;
  bit m_lap  = 1'b0;

  function automatic int next_pos(int p, bit d);
    return d ? (p + DEPTH - 1) % DEPTH : (p + 1) % DEPTH;
  endfunction

  function automatic int end_pos(bit d);
    return d ? 0 : DEPTH - 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= P_IDLE;
      m_pos  <= 0;
      m_left <= 0;
      m_lap  <= 1'b0;
    end else if (!en || mode == 2'd0) begin
      m_ph  <= P_IDLE;
      m_lap <= 1'b0;
    end else begin
      case (m_ph)
        P_IDLE: m_ph <= P_PRES;
        P_PRES: begin
          if (out_ready) begin
            m_ph   <= P_WAIT;
            m_left <= DIV;
          end
        end
        P_WAIT: begin
          if (mode == 2'd3) begin
            if (step) begin
              m_pos <= next_pos(m_pos, dir);
              m_lap <= 1'b1;
              m_ph  <= P_PRES;
            end
          end else if (m_left == 1) begin
            if (mode == 2'd2 && m_lap &&
                m_pos == end_pos(dir)) begin
              m_ph <= P_DONE;
            end else begin
              m_pos <= next_pos(m_pos, dir);
              m_lap <= 1'b1;
              m_ph  <= P_PRES;
            end
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: begin
          if (mode != 2'd2) begin
            m_ph  <= P_IDLE;
            m_lap <= 1'b0;
          end
        end
      endcase
    end
  end

  int cyc_n = 0;
  int hs_addr[$];
  int hs_data[$];
  int hs_cyc[$];

  task automatic cmp_model();
    check("valid", out_valid, m_ph == P_PRES);
    check("done", done, m_ph == P_DONE);
    check("addr", out_addr, m_pos);
    check("data", out_data, digits[m_pos]);
  endtask

  task automatic cyc();
    if (out_valid && out_ready) begin
      hs_addr.push_back(int'(out_addr));
      hs_data.push_back(int'(out_data));
      hs_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    cmp_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    dir = 1'b0;
    step = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_addr", out_addr, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    hs_addr.delete();
    hs_data.delete();
    hs_cyc.delete();
  endtask

  task automatic seek(input int a, input string tag);
    for (int k = 0; k < 50; k++) begin
      if (out_valid && out_addr == ADDR_W'(a)) break;
      cyc();
    end
    check(tag, out_valid && out_addr == ADDR_W'(a), 1);
  endtask

  int exp_run_data [9] = '{0, 0, 9, 5, 7, 2, 0, 2, 0};
  int exp_os_addr  [9] = '{0, 7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    // RUN ascending, continuous ready
    do_reset();
    en = 1'b1; mode = 2'd1; out_ready = 1'b1;
    cyc();
    check("run_first_valid", out_valid, 1);
    repeat (45) cyc();
    check("run_hs_count", hs_addr.size() >= 9, 1);
    for (int i = 0; i < 9; i++) begin
      if (i < hs_addr.size()) begin
        check("run_addr", hs_addr[i], i % DEPTH);
        check("run_data", hs_data[i], exp_run_data[i]);
        if (i > 0)
          check("run_gap", hs_cyc[i] - hs_cyc[i-1], DIV + 1);
      end
    end

    // ONESHOT descending from addr 0
    do_reset();
    en = 1'b1; mode = 2'd2; dir = 1'b1; out_ready = 1'b1;
    repeat (50) cyc();
    check("os_done", done, 1);
    check("os_hs_count", hs_addr.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < hs_addr.size())
        check("os_addr", hs_addr[i], exp_os_addr[i]);
    end
    mode = 2'd0;
    cyc();
    check("os_hold_clears_done", done, 0);

    // Backpressure on addr 2
    do_reset();
    en = 1'b1; mode = 2'd1; out_ready = 1'b1;
    seek(2, "bp_reach");
    out_ready = 1'b0;
    repeat (10) begin
      cyc();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 9);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("bp_gap_valid", out_valid, 0);
    repeat (3) begin
      cyc();
      check("bp_gap_valid", out_valid, 0);
    end
    cyc();
    check("bp_next_valid", out_valid, 1);
    check("bp_next_addr", out_addr, 3);

    // STEP mode
    do_reset();
    en = 1'b1; mode = 2'd3; out_ready = 1'b1;
    cyc();
    cyc();
    out_ready = 1'b0;
    repeat (20) cyc();
    check("step_wait_valid", out_valid, 0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("step_valid", out_valid, 1);
    check("step_addr", out_addr, 1);
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("step_present_addr", out_addr, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    cyc();
    check("step_no_queue", out_valid, 0);

    // en dropped in WAIT at addr 4
    do_reset();
    en = 1'b1; mode = 2'd1; out_ready = 1'b1;
    seek(4, "en_reach");
    cyc();
    en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    cyc();
    check("en_resume_valid", out_valid, 1);
    check("en_resume_addr", out_addr, 4);
    check("en_resume_data", out_data, 7);

    // Asynchronous reset mid-PRESENT at addr 5
    do_reset();
    en = 1'b1; mode = 2'd1; out_ready = 1'b1;
    seek(5, "arst_reach");
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_addr", out_addr, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    check("arst_first_addr", out_addr, 0);
    check("arst_first_data", out_data, 0);
    check("arst_first_valid", out_valid, 1);

    // Random stimulus against the model
    do_reset();
    en = 1'b1; mode = 2'd1;
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 19) == 0) begin
        mode = ($urandom_range(0, 9) == 0) ? 2'd0
             : 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      step = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule
